// File: rtl/elevator_system.sv
// -----------------------------------------------------------------------------
// elevator_system
//   Group controller for four elevator cars serving floors 0..NUM_FLOORS-1.
//   Hall calls (up/down per floor) are latched as pending calls and, one cycle
//   later, each is handed to a single car. Cab calls go straight into their
//   car's target set. Each car runs an IDLE/UP/DOWN/DOOR motion FSM. Car
//   position is tracked internally by counting floor steps; there are no
//   position sensors.
//
// Ports
//   clk                          system clock, all state on the rising edge
//   rst                          asynchronous active-low reset
//   in0..in10          [1:0]     hall call at floor k: bit0 up, bit1 down
//   req_in_lift1..4    [10:0]    cab calls for car n, bit k = floor k
//   motor_signal1..4   [1:0]     registered motor command: 00 stop, 01 up, 10 down
//
// Optional feature (macro ELEV_FLOOR_OUT_EN)
//   When defined, adds floor1..floor4 [3:0]: current floor of each car.
//   When undefined, those ports and their logic are absent.
// -----------------------------------------------------------------------------
module elevator_system #(
    parameter int NUM_FLOORS  = 11,
    parameter int STEP_CYCLES = 1,
    parameter int DOOR_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [1:0]            in0,
    input  logic [1:0]            in1,
    input  logic [1:0]            in2,
    input  logic [1:0]            in3,
    input  logic [1:0]            in4,
    input  logic [1:0]            in5,
    input  logic [1:0]            in6,
    input  logic [1:0]            in7,
    input  logic [1:0]            in8,
    input  logic [1:0]            in9,
    input  logic [1:0]            in10,
    input  logic [NUM_FLOORS-1:0] req_in_lift1,
    input  logic [NUM_FLOORS-1:0] req_in_lift2,
    input  logic [NUM_FLOORS-1:0] req_in_lift3,
    input  logic [NUM_FLOORS-1:0] req_in_lift4,
    output logic [1:0]            motor_signal1,
    output logic [1:0]            motor_signal2,
    output logic [1:0]            motor_signal3,
    output logic [1:0]            motor_signal4
`ifdef ELEV_FLOOR_OUT_EN
    ,
    output logic [3:0]            floor1,
    output logic [3:0]            floor2,
    output logic [3:0]            floor3,
    output logic [3:0]            floor4
`endif
);

    localparam int NC = 4;           // number of cars
    localparam int NF = NUM_FLOORS;  // the hall port list fixes this at 11
    localparam int CW = 8;           // step / dwell counter width

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_UP   = 2'd1,
        S_DOWN = 2'd2,
        S_DOOR = 2'd3
    } state_t;

    function automatic logic any_above(input logic [NF-1:0] t, input logic [3:0] f);
        logic r;
        r = 1'b0;
        for (int i = 0; i < NF; i++) if (i > int'(f) && t[i]) r = 1'b1;
        return r;
    endfunction

    function automatic logic any_below(input logic [NF-1:0] t, input logic [3:0] f);
        logic r;
        r = 1'b0;
        for (int i = 0; i < NF; i++) if (i < int'(f) && t[i]) r = 1'b1;
        return r;
    endfunction

    function automatic logic [NF-1:0] onehot(input logic [3:0] f);
        logic [NF-1:0] r;
        for (int i = 0; i < NF; i++) r[i] = (i == int'(f));
        return r;
    endfunction

    // Per-car motion state
    state_t [NC-1:0]          state_q,  state_d;
    logic   [NC-1:0][3:0]     floor_q,  floor_d;
    logic   [NC-1:0][CW-1:0]  cnt_q,    cnt_d;
    logic   [NC-1:0]          dir_up_q, dir_up_d;   // direction of the last move
    logic   [NC-1:0][1:0]     motor_q,  motor_d;

    // Call bookkeeping
    logic   [NC-1:0][NF-1:0]  cab_q,    cab_d;
    logic   [NC-1:0][NF-1:0]  asg_up_q, asg_up_d;   // hall-up calls owned by car
    logic   [NC-1:0][NF-1:0]  asg_dn_q, asg_dn_d;   // hall-down calls owned by car
    logic   [NF-1:0]          hall_up_q, hall_up_d; // latched, not yet assigned
    logic   [NF-1:0]          hall_dn_q, hall_dn_d;

    logic   [NC-1:0][NF-1:0]  cab_req;
    logic   [NC-1:0][NF-1:0]  door_at;              // floor a car is serving
    logic   [NF-1:0]          hall_up_in, hall_dn_in, door_any;

    // Down at the bottom floor and up at the top floor have no meaning.
    logic unused_hall_bits;
    assign unused_hall_bits = ^{in0[1], in10[0]};

    always_comb begin
        hall_up_in = {1'b0,    in9[0], in8[0], in7[0], in6[0], in5[0],
                      in4[0],  in3[0], in2[0], in1[0], in0[0]};
        hall_dn_in = {in10[1], in9[1], in8[1], in7[1], in6[1], in5[1],
                      in4[1],  in3[1], in2[1], in1[1], 1'b0};
        cab_req[0] = req_in_lift1;
        cab_req[1] = req_in_lift2;
        cab_req[2] = req_in_lift3;
        cab_req[3] = req_in_lift4;
    end

    // -------------------------------------------------------------------------
    // Car motion FSMs
    // -------------------------------------------------------------------------
    always_comb begin
        logic [NF-1:0] tgt;
        logic          up_w, dn_w;
        // NOTE: every variable gets a default before any branch so that no
        // path leaves it unassigned, which would otherwise infer a latch.
        tgt      = '0;
        up_w     = 1'b0;
        dn_w     = 1'b0;
        state_d  = state_q;
        floor_d  = floor_q;
        cnt_d    = cnt_q;
        dir_up_d = dir_up_q;
        motor_d  = '0;
        door_at  = '0;
        for (int c = 0; c < NC; c++) begin
            tgt  = cab_q[c] | asg_up_q[c] | asg_dn_q[c];
            up_w = any_above(tgt, floor_q[c]);
            dn_w = any_below(tgt, floor_q[c]);
            case (state_q[c])
                S_IDLE: begin
                    cnt_d[c] = '0;
                    if ((tgt & onehot(floor_q[c])) != '0) begin
                        state_d[c] = S_DOOR;
                    end else if (up_w) begin
                        state_d[c]  = S_UP;
                        dir_up_d[c] = 1'b1;
                    end else if (dn_w) begin
                        state_d[c]  = S_DOWN;
                        dir_up_d[c] = 1'b0;
                    end
                end
                S_UP: begin
                    // Nothing left above means we cannot run past the top
                    // floor; the car parks and re-evaluates from IDLE.
                    if (!up_w) begin
                        state_d[c] = S_IDLE;
                        cnt_d[c]   = '0;
                    end else if (cnt_q[c] == CW'(STEP_CYCLES - 1)) begin
                        floor_d[c] = floor_q[c] + 4'd1;
                        cnt_d[c]   = '0;
                        if ((tgt & onehot(floor_q[c] + 4'd1)) != '0) state_d[c] = S_DOOR;
                    end else begin
                        cnt_d[c] = cnt_q[c] + CW'(1);
                    end
                end
                S_DOWN: begin
                    if (!dn_w) begin
                        state_d[c] = S_IDLE;
                        cnt_d[c]   = '0;
                    end else if (cnt_q[c] == CW'(STEP_CYCLES - 1)) begin
                        floor_d[c] = floor_q[c] - 4'd1;
                        cnt_d[c]   = '0;
                        if ((tgt & onehot(floor_q[c] - 4'd1)) != '0) state_d[c] = S_DOOR;
                    end else begin
                        cnt_d[c] = cnt_q[c] + CW'(1);
                    end
                end
                S_DOOR: begin
                    if (cnt_q[c] == CW'(DOOR_CYCLES - 1)) begin
                        cnt_d[c] = '0;
                        if (dir_up_q[c] && up_w) begin
                            state_d[c] = S_UP;
                        end else if (!dir_up_q[c] && dn_w) begin
                            state_d[c] = S_DOWN;
                        end else if (up_w) begin
                            state_d[c]  = S_UP;
                            dir_up_d[c] = 1'b1;
                        end else if (dn_w) begin
                            state_d[c]  = S_DOWN;
                            dir_up_d[c] = 1'b0;
                        end else begin
                            state_d[c] = S_IDLE;
                        end
                    end else begin
                        cnt_d[c] = cnt_q[c] + CW'(1);
                    end
                end
                default: state_d[c] = S_IDLE;
            endcase

            motor_d[c] = (state_d[c] == S_UP)   ? 2'b01 :
                         (state_d[c] == S_DOWN) ? 2'b10 : 2'b00;

            // Covers the entry edge and the whole dwell including the exit
            // edge, so a call for this floor that shows up while the door is
            // open is absorbed instead of re-opening the door.
            if (state_d[c] == S_DOOR || state_q[c] == S_DOOR)
                door_at[c] = onehot(floor_d[c]);
        end
    end

    // -------------------------------------------------------------------------
    // Hall call latching / assignment and cab call latching
    // -------------------------------------------------------------------------
    always_comb begin
        logic [NC-1:0] win;
        logic [NF-1:0] any_up, any_dn;
        int            best_d, d, fl;
        win       = '0;
        any_up    = '0;
        any_dn    = '0;
        best_d    = 0;
        d         = 0;
        fl        = 0;
        door_any  = '0;
        asg_up_d  = asg_up_q;
        asg_dn_d  = asg_dn_q;
        hall_up_d = hall_up_q;
        hall_dn_d = hall_dn_q;
        cab_d     = '0;

        for (int c = 0; c < NC; c++) door_any = door_any | door_at[c];

        // Nearest eligible car wins; the strict '<' hands ties to the lowest
        // car index. A call with no eligible car simply stays pending.
        for (int f = 0; f < NF; f++) begin
            if (hall_up_q[f]) begin
                win    = '0;
                best_d = NF;
                for (int c = 0; c < NC; c++) begin
                    fl = int'(floor_q[c]);
                    d  = (fl > f) ? fl - f : f - fl;
                    if ((state_q[c] == S_IDLE || (state_q[c] == S_UP && fl < f)) && d < best_d) begin
                        best_d = d;
                        win    = '0;
                        win[c] = 1'b1;
                    end
                end
                for (int c = 0; c < NC; c++) if (win[c]) asg_up_d[c][f] = 1'b1;
                if (win != '0) hall_up_d[f] = 1'b0;
            end
            if (hall_dn_q[f]) begin
                win    = '0;
                best_d = NF;
                for (int c = 0; c < NC; c++) begin
                    fl = int'(floor_q[c]);
                    d  = (fl > f) ? fl - f : f - fl;
                    if ((state_q[c] == S_IDLE || (state_q[c] == S_DOWN && fl > f)) && d < best_d) begin
                        best_d = d;
                        win    = '0;
                        win[c] = 1'b1;
                    end
                end
                for (int c = 0; c < NC; c++) if (win[c]) asg_dn_d[c][f] = 1'b1;
                if (win != '0) hall_dn_d[f] = 1'b0;
            end
        end

        // A call already owned by a car is not latched again while held.
        for (int c = 0; c < NC; c++) begin
            any_up = any_up | asg_up_d[c];
            any_dn = any_dn | asg_dn_d[c];
        end
        hall_up_d = (hall_up_d | (hall_up_in & ~any_up)) & ~door_any;
        hall_dn_d = (hall_dn_d | (hall_dn_in & ~any_dn)) & ~door_any;

        // An open door serves the hall calls at its floor for every car,
        // but only clears its own car's cab call.
        for (int c = 0; c < NC; c++) begin
            asg_up_d[c] = asg_up_d[c] & ~door_any;
            asg_dn_d[c] = asg_dn_d[c] & ~door_any;
            cab_d[c]    = (cab_q[c] | cab_req[c]) & ~door_at[c];
        end
    end

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            // NOTE: the call arrays are ordinary flops and must be reset; a
            // stale bit after reset would send a car off on its own.
            hall_up_q <= '0;
            hall_dn_q <= '0;
            cab_q     <= '0;
            asg_up_q  <= '0;
            asg_dn_q  <= '0;
            floor_q   <= '0;
            cnt_q     <= '0;
            dir_up_q  <= '0;
            motor_q   <= '0;
            for (int c = 0; c < NC; c++) state_q[c] <= S_IDLE;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the values
            // computed from the previous state, regardless of statement order.
            hall_up_q <= hall_up_d;
            hall_dn_q <= hall_dn_d;
            cab_q     <= cab_d;
            asg_up_q  <= asg_up_d;
            asg_dn_q  <= asg_dn_d;
            floor_q   <= floor_d;
            cnt_q     <= cnt_d;
            dir_up_q  <= dir_up_d;
            motor_q   <= motor_d;
            state_q   <= state_d;
        end
    end

    assign motor_signal1 = motor_q[0];
    assign motor_signal2 = motor_q[1];
    assign motor_signal3 = motor_q[2];
    assign motor_signal4 = motor_q[3];

`ifdef ELEV_FLOOR_OUT_EN
    assign floor1 = floor_q[0];
    assign floor2 = floor_q[1];
    assign floor3 = floor_q[2];
    assign floor4 = floor_q[3];
`endif

endmodule

// File: tb/tb_elevator_system.sv
// -----------------------------------------------------------------------------
// tb_elevator_system
//   Self-checking bench for elevator_system. Each scenario is described by a
//   table of stimulus events (tick, hall or cab input, value) and a table of
//   expected motor runs ({motor4..motor1}, cycle count). Expected runs are
//   pushed into a scoreboard queue when the scenario starts and popped one
//   per cycle when the DUT output is sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_elevator_system;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  hall [11];
    logic [10:0] cab  [4];
    logic [1:0]  m1, m2, m3, m4;
`ifdef ELEV_FLOOR_OUT_EN
    logic [3:0]  f1, f2, f3, f4;
`endif

    always #5 clk = ~clk;

    elevator_system dut (
        .clk           (clk),
        .rst           (rst),
        .in0           (hall[0]),
        .in1           (hall[1]),
        .in2           (hall[2]),
        .in3           (hall[3]),
        .in4           (hall[4]),
        .in5           (hall[5]),
        .in6           (hall[6]),
        .in7           (hall[7]),
        .in8           (hall[8]),
        .in9           (hall[9]),
        .in10          (hall[10]),
        .req_in_lift1  (cab[0]),
        .req_in_lift2  (cab[1]),
        .req_in_lift3  (cab[2]),
        .req_in_lift4  (cab[3]),
        .motor_signal1 (m1),
        .motor_signal2 (m2),
        .motor_signal3 (m3),
        .motor_signal4 (m4)
`ifdef ELEV_FLOOR_OUT_EN
        ,
        .floor1        (f1),
        .floor2        (f2),
        .floor3        (f3),
        .floor4        (f4)
`endif
    );

    typedef struct {
        int          scen;
        int          at;
        bit          is_cab;
        int          idx;
        logic [10:0] bits;
    } stim_t;

    typedef struct {
        int         scen;
        logic [7:0] mot;   // {m4, m3, m2, m1}
        int         n;
    } exp_t;

    stim_t      stims [$];
    exp_t       exps  [$];
    logic [7:0] sbq   [$];
    int         tests_run    = 0;
    int         tests_failed = 0;

    localparam logic [1:0] S = 2'b00, U = 2'b01, D = 2'b10;

    function automatic logic [7:0] mk(input logic [1:0] a, b, c, d);
        return {d, c, b, a};
    endfunction

    task automatic add_stim(input int s, at, input bit is_cab, input int idx, input logic [10:0] bits);
        stim_t st;
        st.scen = s; st.at = at; st.is_cab = is_cab; st.idx = idx; st.bits = bits;
        stims.push_back(st);
    endtask

    task automatic add_exp(input int s, input logic [7:0] mot, input int n);
        exp_t e;
        e.scen = s; e.mot = mot; e.n = n;
        exps.push_back(e);
    endtask

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: motors(4..1) got %b, expected %b", name, act, exp);
        end
    endtask

    task automatic clear_inputs();
        for (int i = 0; i < 11; i++) hall[i] = 2'b00;
        for (int i = 0; i < 4; i++) cab[i] = '0;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    // Runs one scenario; must be entered right after a falling edge.
    task automatic run_scen(input int s, input string name);
        int         len;
        logic [7:0] e;
        len = 0;
        foreach (exps[i]) begin
            if (exps[i].scen == s) begin
                for (int k = 0; k < exps[i].n; k++) sbq.push_back(exps[i].mot);
                len += exps[i].n;
            end
        end
        for (int t = 0; t < len; t++) begin
            clear_inputs();
            foreach (stims[i]) begin
                if (stims[i].scen == s && stims[i].at == t) begin
                    if (stims[i].is_cab) cab[stims[i].idx]  = stims[i].bits;
                    else                 hall[stims[i].idx] = stims[i].bits[1:0];
                end
            end
            @(negedge clk);
            e = sbq.pop_front();
            check($sformatf("%s[%0d]", name, t), {m4, m3, m2, m1}, e);
        end
        clear_inputs();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        // ---- scenario tables -------------------------------------------------
        // 0: idle after reset
        add_exp(0, mk(S, S, S, S), 3);
        // 1: single hall call up+down at 7; car1 wins the four-way tie
        add_stim(1, 0, 0, 7, 11'b11);
        add_exp(1, mk(S, S, S, S), 2);
        add_exp(1, mk(U, S, S, S), 7);
        add_exp(1, mk(S, S, S, S), 4);
        // 2: in7 then in6 while car1 climbs; car2 takes the down call at 6,
        //    which car1's door at 6 then serves, so car2 parks
        add_stim(2, 0, 0, 7, 11'b11);
        add_stim(2, 3, 0, 6, 11'b11);
        add_exp(2, mk(S, S, S, S), 2);
        add_exp(2, mk(U, S, S, S), 3);
        add_exp(2, mk(U, U, S, S), 3);
        add_exp(2, mk(S, U, S, S), 1);
        add_exp(2, mk(S, S, S, S), 1);
        add_exp(2, mk(U, S, S, S), 1);
        add_exp(2, mk(S, S, S, S), 3);
        // 3: cab call 9 for car1 at floor 7
        add_stim(3, 0, 1, 0, 11'b010_0000_0000);
        add_exp(3, mk(S, S, S, S), 1);
        add_exp(3, mk(U, S, S, S), 2);
        add_exp(3, mk(S, S, S, S), 3);
        // 4: cab call 0 for car1 at floor 9
        add_stim(4, 0, 1, 0, 11'b000_0000_0001);
        add_exp(4, mk(S, S, S, S), 1);
        add_exp(4, mk(D, S, S, S), 9);
        add_exp(4, mk(S, S, S, S), 3);
        // 5: meaningless down-at-0 and up-at-10 requests
        add_stim(5, 0, 0, 0, 11'b10);
        add_stim(5, 0, 0, 10, 11'b01);
        add_exp(5, mk(S, S, S, S), 6);
        // 6: up call at 2; car2 idle at 3 is nearest
        add_stim(6, 0, 0, 2, 11'b01);
        add_exp(6, mk(S, S, S, S), 2);
        add_exp(6, mk(S, D, S, S), 1);
        add_exp(6, mk(S, S, S, S), 3);
        // 7: every car heads up to 10; down call at 1 waits for car2 to idle
        for (int c = 0; c < 4; c++) add_stim(7, 0, 1, c, 11'b100_0000_0000);
        add_stim(7, 2, 0, 1, 11'b10);
        add_exp(7, mk(S, S, S, S), 1);
        add_exp(7, mk(U, U, U, U), 8);
        add_exp(7, mk(U, S, U, U), 2);
        add_exp(7, mk(S, S, S, S), 2);
        add_exp(7, mk(S, D, S, S), 9);
        add_exp(7, mk(S, S, S, S), 3);
        // 8: car1 starts down from 10 (interrupted by reset)
        add_stim(8, 0, 1, 0, 11'b000_0000_0001);
        add_exp(8, mk(S, S, S, S), 1);
        add_exp(8, mk(D, S, S, S), 3);
        // 9: after reset, up call at 3 proves car1 restarted from floor 0
        add_stim(9, 0, 0, 3, 11'b01);
        add_exp(9, mk(S, S, S, S), 2);
        add_exp(9, mk(U, S, S, S), 3);
        add_exp(9, mk(S, S, S, S), 3);

        // ---- sequence ----------------------------------------------------------
        clear_inputs();
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_state", {m4, m3, m2, m1}, 8'h00);
        rst = 1'b1;
        run_scen(0, "idle");
        run_scen(1, "single_call");
`ifdef ELEV_FLOOR_OUT_EN
        check("floor1_at_7", {4'h0, f1}, 8'd7);
`endif
        do_reset();
        run_scen(2, "second_call");
        run_scen(3, "cab_up9");
        run_scen(4, "cab_down0");
        run_scen(5, "boundary");
        run_scen(6, "nearest_idle");
        run_scen(7, "contention");
        run_scen(8, "pre_reset");

        // Mid-motion reset: motors must drop without waiting for a clock edge.
        check("moving_before_reset", {m4, m3, m2, m1}, mk(D, S, S, S));
        rst = 1'b0;
        #1;
        check("async_reset_motors", {m4, m3, m2, m1}, 8'h00);
        @(negedge clk);
        check("held_reset_motors", {m4, m3, m2, m1}, 8'h00);
        rst = 1'b1;
        run_scen(9, "post_reset");

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
